serial_adder_ctrl: RTL

//   Bit-serial adder engine that sits upstream of the half-adder cells.
//   - Latches two WIDTH-bit operands on a start handshake.
//   - Presents the operands LSB-first to a pair of ha_cell instances (one full adder) and keeps the carry in a flop.
//   - Shifts the sum bits into a result register and returns a WIDTH+1-bit result with a done pulse.
//   - Exposes a busy flag so the pin-level wrapper can sequence operations from ui_in/uio_in.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/ha_cell.sv | 16 +
 rtl/serial_adder_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the bit-counter width helper.
package serial_add_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Counter must hold 0..w.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/ha_cell.sv
// Half-adder cell; two instances plus an OR form the serial full adder.
// Ports:
//   a, b : input bits
//   s    : sum  (a ^ b)
//   c    : carry (a & b)
module ha_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder engine. Captures two operands on start, adds them
// LSB-first through one full adder (two ha_cell + OR) with a carry flop, and
// returns {carry_out, sum} with a one-cycle done pulse.
// Optional feature macro: SERIAL_SUB_EN enables subtraction via the sub input.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : enable; low freezes all state
//   start      : request a new operation (honoured in IDLE only)
//   op_a, op_b : operands, captured on accepted start
//   sub        : subtract request (only with SERIAL_SUB_EN)
//   busy       : high in SHIFT and DONE
//   done       : high for the one enabled cycle spent in DONE
//   result     : {carry_out, sum}, held until the next operation overwrites it
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   result
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] b_in_c;
  logic             carry_in_c;
  logic             s0_c, c0_c, fa_s_c, c1_c, fa_c_c;

  // Operand B / carry-in selection at accept time.
`ifdef SERIAL_SUB_EN
  assign b_in_c     = sub ? ~op_b : op_b;
  assign carry_in_c = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_in_c     = op_b;
  assign carry_in_c = 1'b0;
`endif

  // Full adder on the current LSBs and the carry flop.
  ha_cell u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(s0_c),   .c(c0_c));
  ha_cell u_ha1 (.a(s0_c),   .b(carry_q), .s(fa_s_c), .c(c1_c));
  assign fa_c_c = c0_c | c1_c;

  // Next-state and datapath update; everything holds when ena is low.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;

    if (ena) begin
      case (state_q)
        IDLE: begin
          done_d = 1'b0;
          if (start) begin
            a_d     = op_a;
            b_d     = b_in_c;
            carry_d = carry_in_c;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          result_d[WIDTH-1:0] = {fa_s_c, result_q[WIDTH-1:1]};
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          carry_d = fa_c_c;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d[WIDTH] = fa_c_c;
            done_d          = 1'b1;
            state_d         = DONE;
          end
        end
        DONE: begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; reset takes priority over ena.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
